// File: rtl/tinyalu_pipe_if.sv
// Request/response bundle for tinyalu_pipe: operands, opcode and handshake toward the ALU,
// result, error flag and done pulse back to the driver.
interface tinyalu_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [2:0]         op;
   logic               start;
   logic               ready_o;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               err_o;

   modport master (output A, B, op, start, input ready_o, done, result, err_o);
   modport slave  (input A, B, op, start, output ready_o, done, result, err_o);
endinterface

// File: rtl/tinyalu_pipe.sv
// Tiny ALU: ADD/AND/XOR (and SUB when TINYALU_SUB_EN is defined) complete in one cycle,
// MUL completes MUL_LAT cycles after acceptance; illegal opcodes return err_o with a zero result.
module tinyalu_pipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic           clk_i,
   input  logic           rst_i,
   tinyalu_pipe_if.slave  bus
);
   localparam int unsigned RES_W = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
`ifdef TINYALU_SUB_EN
   localparam logic [2:0] OP_SUB = 3'b101;
`endif

   typedef enum logic {ST_IDLE, ST_MBUSY} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               done_q, done_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               err_q, err_d;
   logic               ready_q, ready_d;
   logic               accept;

   assign accept = bus.start && ready_q;

   // Single-cycle ops resolve at acceptance; MUL captures operands and counts down.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      done_d   = 1'b0;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_NOP: ;
                  OP_ADD: begin
                     done_d   = 1'b1;
                     err_d    = 1'b0;
                     result_d = RES_W'(bus.A) + RES_W'(bus.B);
                  end
                  OP_AND: begin
                     done_d   = 1'b1;
                     err_d    = 1'b0;
                     result_d = RES_W'(bus.A & bus.B);
                  end
                  OP_XOR: begin
                     done_d   = 1'b1;
                     err_d    = 1'b0;
                     result_d = RES_W'(bus.A ^ bus.B);
                  end
`ifdef TINYALU_SUB_EN
                  OP_SUB: begin
                     done_d   = 1'b1;
                     err_d    = 1'b0;
                     result_d = RES_W'(bus.A) - RES_W'(bus.B);
                  end
`endif
                  OP_MUL: begin
                     state_d = ST_MBUSY;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                     a_d     = bus.A;
                     b_d     = bus.B;
                  end
                  default: begin
                     done_d   = 1'b1;
                     err_d    = 1'b1;
                     result_d = '0;
                  end
               endcase
            end
         end
         ST_MBUSY: begin
            // Last busy cycle: publish the product so done lands exactly MUL_LAT after accept.
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               done_d   = 1'b1;
               err_d    = 1'b0;
               result_d = RES_W'(a_q) * RES_W'(b_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.done    = done_q;
   assign bus.result  = result_q;
   assign bus.err_o   = err_q;
endmodule

// File: tb/tb_tinyalu_pipe.sv
// Scoreboard bench for tinyalu_pipe: directed vectors push expected responses (value, error, done cycle)
// and per-instance monitors pop and compare on every done pulse.
module tb_tinyalu_pipe;
   localparam int unsigned WIDTH = 8;

   typedef struct {
      logic [15:0] res;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t q5[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tinyalu_pipe_if #(.WIDTH(WIDTH)) bus ();
   tinyalu_pipe_if #(.WIDTH(WIDTH)) bus5 ();

   tinyalu_pipe #(.WIDTH(WIDTH), .MUL_LAT(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   tinyalu_pipe #(.WIDTH(WIDTH), .MUL_LAT(5)) dut5 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus5)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
   endtask

   task automatic expect_resp(input logic [15:0] r, input logic e, input int lat);
      exp_t x;
      x.res = r;
      x.err = e;
      x.cyc = cyc + lat;
      q.push_back(x);
   endtask

   // Monitor for the MUL_LAT=3 instance
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done cyc=%0d result=0x%0h required=no_done", cyc, bus.result);
         end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("result", 32'(bus.result), 32'(e.res));
            chk("err_o", 32'(bus.err_o), 32'(e.err));
         end
      end
   end

   // Monitor for the MUL_LAT=5 instance
   always @(negedge clk) begin : mon5
      exp_t e;
      if (bus5.done === 1'b1) begin
         if (q5.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done5 cyc=%0d result=0x%0h required=no_done", cyc, bus5.result);
         end else begin
            e = q5.pop_front();
            chk("done_cycle5", cyc, e.cyc);
            chk("result5", 32'(bus5.result), 32'(e.res));
            chk("err_o5", 32'(bus5.err_o), 32'(e.err));
         end
      end
   end

   initial begin
      exp_t x;
      bus.start  = 1'b1;
      bus.op     = 3'b001;
      bus.A      = 8'h01;
      bus.B      = 8'h01;
      bus5.start = 1'b0;
      bus5.op    = 3'b000;
      bus5.A     = 8'h00;
      bus5.B     = 8'h00;

      // Reset held two cycles with an ADD request pending
      step();
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_err", 32'(bus.err_o), 32'd0);
      step();
      rst       = 1'b0;
      bus.start = 1'b0;
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_ready5", 32'(bus5.ready_o), 32'd1);

      // Back-to-back single-cycle ops
      drive(3'b001, 8'hFF, 8'h01); expect_resp(16'h0100, 1'b0, 1); step();
      drive(3'b010, 8'hF0, 8'h3C); expect_resp(16'h0030, 1'b0, 1); step();
      drive(3'b011, 8'hAA, 8'h55); expect_resp(16'h00FF, 1'b0, 1); step();
      bus.start = 1'b0;

      // MUL with requests ignored while busy, then accept in the done cycle
      drive(3'b100, 8'hFF, 8'hFF); expect_resp(16'hFE01, 1'b0, 3); step();
      chk("busy_ready_n1", 32'(bus.ready_o), 32'd0);
      drive(3'b001, 8'h01, 8'h02); step();
      chk("busy_ready_n2", 32'(bus.ready_o), 32'd0);
      step();
      chk("done_ready_n3", 32'(bus.ready_o), 32'd1);
      drive(3'b001, 8'h02, 8'h03); expect_resp(16'h0005, 1'b0, 1); step();
      bus.start = 1'b0;
      step();

      // MUL aborted by reset
      drive(3'b100, 8'd12, 8'd10); step();
      bus.start = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_ready", 32'(bus.ready_o), 32'd1);
      for (int i = 0; i < 5; i++) step();

      // NOP leaves result and err_o untouched
      drive(3'b001, 8'h10, 8'h20); expect_resp(16'h0030, 1'b0, 1); step();
      drive(3'b000, 8'h09, 8'h09); step();
      bus.start = 1'b0;
      step();
      chk("nop_result", 32'(bus.result), 32'h30);
      chk("nop_err", 32'(bus.err_o), 32'd0);
      chk("nop_ready", 32'(bus.ready_o), 32'd1);

      // Illegal opcode, then NOP
      drive(3'b110, 8'd3, 8'd4); expect_resp(16'h0000, 1'b1, 1); step();
      drive(3'b000, 8'h77, 8'h11); step();
      bus.start = 1'b0;
      step();
      chk("ill_nop_result", 32'(bus.result), 32'd0);
      chk("ill_nop_err", 32'(bus.err_o), 32'd1);
      drive(3'b111, 8'hFF, 8'hFF); expect_resp(16'h0000, 1'b1, 1); step();

      // Opcode 101: SUB when enabled, illegal otherwise
`ifdef TINYALU_SUB_EN
      drive(3'b101, 8'h05, 8'h07); expect_resp(16'hFFFE, 1'b0, 1); step();
`else
      drive(3'b101, 8'h05, 8'h07); expect_resp(16'h0000, 1'b1, 1); step();
`endif
      bus.start = 1'b0;

      // MUL followed by a MUL accepted in the done cycle
      drive(3'b100, 8'd3, 8'd4); expect_resp(16'd12, 1'b0, 3); step();
      bus.start = 1'b0;
      step();
      step();
      chk("mul_chain_ready", 32'(bus.ready_o), 32'd1);
      drive(3'b100, 8'h80, 8'h02); expect_resp(16'h0100, 1'b0, 3); step();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // MUL_LAT=5 instance
      bus5.start = 1'b1;
      bus5.op    = 3'b100;
      bus5.A     = 8'd12;
      bus5.B     = 8'd10;
      x.res = 16'h0078;
      x.err = 1'b0;
      x.cyc = cyc + 5;
      q5.push_back(x);
      step();
      bus5.start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("ready5_busy", 32'(bus5.ready_o), 32'd0);
         step();
      end
      chk("ready5_done", 32'(bus5.ready_o), 32'd1);

      for (int i = 0; i < 4; i++) step();
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("queue5_empty", 32'(q5.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
